float_div_scheduler: RTL and testbench
======================================

// Module: float_div_scheduler
// PURPOSE
//  Round-robin scheduler sharing one iterative 8-bit float divider (sign[7], exp[6:4], mant[3:0])
//  among NUM_REQ requesters. Accepts one request at a time, issues it to the divider, waits for done,
//  and returns quotient/remainder tagged with the requester ID. Sits between client FSMs and the divider.
// PARAMETERS
//  NUM_REQ        4   number of requesters (2..8)
//  ID_W           2   requester-ID width, = $clog2(NUM_REQ)
//  TIMEOUT_CYCLES 64  divider watchdog limit, cycles in WAIT (FLOAT_DIV_TIMEOUT_EN only)
// PORTS
//  clock          in   1          rising-edge clock
//  reset          in   1          asynchronous, active-low reset
//  req_valid      in   NUM_REQ    per-requester request valid
//  req_num        in   8*NUM_REQ  numerators, requester i at [8*i+7:8*i]
//  req_den        in   8*NUM_REQ  denominators, same packing
//  req_ready      out  NUM_REQ    one-hot grant; handshake = valid & ready
//  div_start      out  1          one-cycle start pulse to divider
//  div_num        out  8          latched numerator to divider
//  div_den        out  8          latched denominator to divider
//  div_done       in   1          divider completion, one-cycle pulse
//  div_quotient   in   4          divider quotient, valid with div_done
//  div_remainder  in   8          divider fixed-point remainder, valid with div_done
//  rsp_valid      out  1          response valid
//  rsp_ready      in   1          response accepted when valid & ready
//  rsp_id         out  ID_W       requester ID of the response
//  rsp_quotient   out  4          captured quotient
//  rsp_remainder  out  8          captured remainder
//  rsp_error      out  1          response is a timeout abort (0 when macro is off)
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, rr pointer 0, all outputs 0, operand/result regs 0.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: req_ready is combinational one-hot of the first asserted req_valid at or after the rr pointer,
//    wrapping at NUM_REQ. No requests -> req_ready=0. On handshake: latch div_num/div_den/rsp_id,
//    set rr pointer = granted+1 mod NUM_REQ, go to ISSUE. req_ready=0 in every other state.
//  - ISSUE: div_start=1 for exactly this one cycle; go to WAIT.
//  - WAIT: on div_done capture quotient/remainder, rsp_error=0, go to RESP. div_done outside WAIT is ignored.
//  - RESP: rsp_valid=1, fields stable until rsp_ready. On rsp_ready go to IDLE, rsp_valid drops next cycle.
//  - Latency: grant edge -> div_start after 1 cycle; div_done -> rsp_valid after 1 cycle.
//  - Throughput: at most one outstanding division. A new grant is possible in the cycle after the response.
//  - div_num/div_den hold their value from grant until the next grant. No arithmetic on operands.
//  - A requester dropping req_valid while not granted is legal. Its request is lost, no state change.
//  - Reset mid-operation: immediate return to IDLE, outputs cleared, the pending division is discarded.
//    The divider is reset by the same net.
// CONFIGURATION
//  FLOAT_DIV_TIMEOUT_EN defined:
//    - A cycle counter clears on entry to WAIT.
//    - If it reaches TIMEOUT_CYCLES with no div_done: go to RESP with rsp_error=1,
//      quotient 0 and remainder 0.
//    - A div_done in the same cycle as the timeout wins (normal response).
//  Not defined: no counter, rsp_error tied to 0, WAIT is unbounded.
// STRUCTURE
//  - Package float_div_pkg:
//    - FLOAT_W=8, EXP_MSB=6, EXP_LSB=4, MANT_W=4, QUOT_W=4, REM_W=8
//    - typedef enum state_t {IDLE, ISSUE, WAIT, RESP}
//  - Sub-module rr_arbiter #(NUM_REQ): req vector + pointer -> one-hot grant + grant index, combinational.
// TESTING
//  - Single req: req0 num=0x48 den=0x28 -> div_start 1 cycle after grant; model done q=0x1 r=0x08
//    -> rsp id=0 q=0x1 r=0x08.
//  - All 4 valid from reset -> grants 0,1,2,3,0 in order. Check that no req_ready asserts outside IDLE.
//  - Backpressure: rsp_ready=0 for 10 cycles -> rsp fields stable, no new grant, no div_start.
//  - Reset asserted in WAIT -> outputs 0 asynchronously. A later div_done is ignored, and the next grant
//    goes to req0.
//  - Timeout, macro on, TIMEOUT_CYCLES=64, no div_done -> rsp_error=1, q=0, r=0 after 64 WAIT cycles.
//    Done at cycle 64 -> normal response.
//  - Stray div_done in IDLE -> no rsp_valid, no state change.

Source files
------------

// File: rtl/float_div_pkg.sv
// Shared types and constants for the float divider scheduler: operand/result
// field geometry and the scheduler FSM state encoding.
package float_div_pkg;

   localparam int FLOAT_W = 8;
   localparam int EXP_MSB = 6;
   localparam int EXP_LSB = 4;
   localparam int MANT_W  = 4;
   localparam int QUOT_W  = 4;
   localparam int REM_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/float_div_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after the pointer, wrapping at NUM_REQ, and reports it one-hot and as an index.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx
);

   // scan NUM_REQ slots starting at the pointer; first hit wins
   always_comb begin
      logic found_v;
      int   k_v;
      grant     = '0;
      grant_idx = '0;
      found_v   = 1'b0;
      k_v       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k_v = (int'(ptr) + i) % NUM_REQ;
         if (!found_v && req[k_v]) begin
            found_v      = 1'b1;
            grant[k_v]   = 1'b1;
            grant_idx    = ID_W'(k_v);
         end else begin
            found_v = found_v;
         end
      end
   end

endmodule

// File: rtl/float_div_scheduler.sv
// Round-robin scheduler sharing one iterative 8-bit float divider among NUM_REQ clients.
// Optional divider watchdog is enabled by defining FLOAT_DIV_TIMEOUT_EN.
module float_div_scheduler
   import float_div_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = $clog2(NUM_REQ)
`ifdef FLOAT_DIV_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 64
`endif
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [FLOAT_W*NUM_REQ-1:0] req_num,
   input  logic [FLOAT_W*NUM_REQ-1:0] req_den,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       div_start,
   output logic [FLOAT_W-1:0]         div_num,
   output logic [FLOAT_W-1:0]         div_den,
   input  logic                       div_done,
   input  logic [QUOT_W-1:0]          div_quotient,
   input  logic [REM_W-1:0]           div_remainder,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_W-1:0]            rsp_id,
   output logic [QUOT_W-1:0]          rsp_quotient,
   output logic [REM_W-1:0]           rsp_remainder,
   output logic                       rsp_error
);

   state_t               state_r;
   state_t               next_state_s;
   logic [ID_W-1:0]      ptr_r;
   logic [NUM_REQ-1:0]   gnt_s;
   logic [ID_W-1:0]      gnt_idx_s;
   logic                 take_s;
   logic                 done_s;
   logic                 timeout_s;
   logic                 div_start_r;
   logic [FLOAT_W-1:0]   div_num_r;
   logic [FLOAT_W-1:0]   div_den_r;
   logic                 rsp_valid_r;
   logic [ID_W-1:0]      rsp_id_r;
   logic [QUOT_W-1:0]    rsp_quotient_r;
   logic [REM_W-1:0]     rsp_remainder_r;
   logic                 rsp_error_r;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr_r),
      .grant     (gnt_s),
      .grant_idx (gnt_idx_s)
   );

   // grants are only offered while idle, so the grant is the handshake itself
   assign req_ready = (state_r == IDLE) ? gnt_s : '0;
   assign take_s    = |(req_valid & req_ready);
   assign done_s    = (state_r == WAIT) && div_done;

`ifdef FLOAT_DIV_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_r;

   // watchdog: held at zero outside WAIT, counts WAIT cycles
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wait_cnt_r <= '0;
      end else if (state_r != WAIT) begin
         wait_cnt_r <= '0;
      end else begin
         wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end
   end

   // a done arriving in the final watchdog cycle still gives a normal response
   assign timeout_s = (state_r == WAIT) && !div_done &&
                      (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_s = 1'b0;
`endif

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (take_s) next_state_s = ISSUE;
            else        next_state_s = IDLE;
         end
         ISSUE: next_state_s = WAIT;
         WAIT: begin
            if (done_s || timeout_s) next_state_s = RESP;
            else                     next_state_s = WAIT;
         end
         RESP: begin
            if (rsp_ready) next_state_s = IDLE;
            else           next_state_s = RESP;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // datapath and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_r           <= '0;
         div_start_r     <= 1'b0;
         div_num_r       <= '0;
         div_den_r       <= '0;
         rsp_valid_r     <= 1'b0;
         rsp_id_r        <= '0;
         rsp_quotient_r  <= '0;
         rsp_remainder_r <= '0;
         rsp_error_r     <= 1'b0;
      end else begin
         div_start_r <= (next_state_s == ISSUE);
         rsp_valid_r <= (next_state_s == RESP);
         if (take_s) begin
            div_num_r <= req_num[int'(gnt_idx_s)*FLOAT_W +: FLOAT_W];
            div_den_r <= req_den[int'(gnt_idx_s)*FLOAT_W +: FLOAT_W];
            rsp_id_r  <= gnt_idx_s;
            ptr_r     <= (gnt_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + ID_W'(1);
         end
         if (done_s) begin
            rsp_quotient_r  <= div_quotient;
            rsp_remainder_r <= div_remainder;
            rsp_error_r     <= 1'b0;
         end else if (timeout_s) begin
            rsp_quotient_r  <= '0;
            rsp_remainder_r <= '0;
            rsp_error_r     <= 1'b1;
         end
      end
   end

   assign div_start     = div_start_r;
   assign div_num       = div_num_r;
   assign div_den       = div_den_r;
   assign rsp_valid     = rsp_valid_r;
   assign rsp_id        = rsp_id_r;
   assign rsp_quotient  = rsp_quotient_r;
   assign rsp_remainder = rsp_remainder_r;
   assign rsp_error     = rsp_error_r;

endmodule

// File: tb/tb_float_div_scheduler.sv
// Self-checking bench for float_div_scheduler: table vectors, random transactions
// against a transaction-level round-robin model, and hand-written corner sequences.
module tb_float_div_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_num;
   logic [31:0] req_den;
   logic [3:0]  req_ready;
   logic        div_start;
   logic [7:0]  div_num;
   logic [7:0]  div_den;
   logic        div_done;
   logic [3:0]  div_quotient;
   logic [7:0]  div_remainder;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_quotient;
   logic [7:0]  rsp_remainder;
   logic        rsp_error;

   int n_checks = 0;
   int n_fail   = 0;
   int ptr_m    = 0;

   float_div_scheduler dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_num       (req_num),
      .req_den       (req_den),
      .req_ready     (req_ready),
      .div_start     (div_start),
      .div_num       (div_num),
      .div_den       (div_den),
      .div_done      (div_done),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_quotient  (rsp_quotient),
      .rsp_remainder (rsp_remainder),
      .rsp_error     (rsp_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] mask;
      logic [7:0] num;
      logic [7:0] den;
      logic [3:0] q;
      logic [7:0] r;
      int         lat;
      int         stall;
      int         exp_id;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   // reference round robin: first requester at or after the pointer, with wrap
   function automatic int model_grant(input logic [3:0] mask);
      for (int i = 0; i < 4; i++) begin
         if (mask[(ptr_m + i) % 4]) return (ptr_m + i) % 4;
      end
      return -1;
   endfunction

   task automatic do_txn(input logic [3:0] mask, input logic [7:0] num, input logic [7:0] den,
                         input logic [3:0] q, input logic [7:0] r, input int lat, input int stall,
                         input int exp_id);
      int         g;
      logic [3:0] gnt;
      g = model_grant(mask);
      if (exp_id >= 0) g = exp_id;
      gnt = 4'b0001 << g;
      for (int i = 0; i < 4; i++) begin
         req_num[8*i +: 8] = 8'($urandom);
         req_den[8*i +: 8] = 8'($urandom);
      end
      req_num[8*g +: 8] = num;
      req_den[8*g +: 8] = den;
      req_valid = mask;
      #1;
      check("grant", 32'(req_ready), 32'(gnt));
      ptr_m = (g + 1) % 4;
      @(negedge clock);
      req_valid = mask & ~gnt;
      #1;
      check("issue_ready", 32'(req_ready), 32'h0);
      check("issue_start", 32'(div_start), 32'h1);
      check("issue_num", 32'(div_num), 32'(num));
      check("issue_den", 32'(div_den), 32'(den));
      check("issue_rsp", 32'(rsp_valid), 32'h0);
      @(negedge clock);
      check("wait_start", 32'(div_start), 32'h0);
      for (int c = 0; c < lat; c++) begin
         check("wait_rsp", 32'(rsp_valid), 32'h0);
         check("wait_ready", 32'(req_ready), 32'h0);
         @(negedge clock);
      end
      div_done      = 1'b1;
      div_quotient  = q;
      div_remainder = r;
      @(negedge clock);
      div_done      = 1'b0;
      div_quotient  = 4'($urandom);
      div_remainder = 8'($urandom);
      check("rsp_valid", 32'(rsp_valid), 32'h1);
      check("rsp_id", 32'(rsp_id), 32'(g));
      check("rsp_q", 32'(rsp_quotient), 32'(q));
      check("rsp_r", 32'(rsp_remainder), 32'(r));
      check("rsp_err", 32'(rsp_error), 32'h0);
      check("rsp_ready_gate", 32'(req_ready), 32'h0);
      for (int c = 0; c < stall; c++) begin
         @(negedge clock);
         check("stall_valid", 32'(rsp_valid), 32'h1);
         check("stall_fields", {22'h0, rsp_id, rsp_quotient, rsp_remainder}, {22'h0, 2'(g), q, r});
         check("stall_start", 32'(div_start), 32'h0);
         check("stall_grant", 32'(req_ready), 32'h0);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      check("rsp_drop", 32'(rsp_valid), 32'h0);
      req_valid = 4'h0;
   endtask

`ifdef FLOAT_DIV_TIMEOUT_EN
   task automatic timeout_txn(input logic send_done);
      int g;
      g = model_grant(4'b0010);
      req_num[8*g +: 8] = 8'h33;
      req_den[8*g +: 8] = 8'h11;
      req_valid = 4'b0010;
      ptr_m = (g + 1) % 4;
      @(negedge clock);
      req_valid = 4'h0;
      @(negedge clock);
      for (int c = 0; c < 63; c++) begin
         check("to_wait", 32'(rsp_valid), 32'h0);
         @(negedge clock);
      end
      check("to_last_wait", 32'(rsp_valid), 32'h0);
      if (send_done) begin
         div_done      = 1'b1;
         div_quotient  = 4'h5;
         div_remainder = 8'h21;
      end
      @(negedge clock);
      div_done = 1'b0;
      check("to_valid", 32'(rsp_valid), 32'h1);
      check("to_err", 32'(rsp_error), send_done ? 32'h0 : 32'h1);
      check("to_q", 32'(rsp_quotient), send_done ? 32'h5 : 32'h0);
      check("to_r", 32'(rsp_remainder), send_done ? 32'h21 : 32'h0);
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
   endtask
`endif

   initial begin
      vec_t vecs[11];
      vecs[0]  = '{4'b1111, 8'h11, 8'h22, 4'h3, 8'h44, 0,  0, 0};
      vecs[1]  = '{4'b1111, 8'h12, 8'h23, 4'h4, 8'h45, 1,  0, 1};
      vecs[2]  = '{4'b1111, 8'h13, 8'h24, 4'h5, 8'h46, 2,  1, 2};
      vecs[3]  = '{4'b1111, 8'h14, 8'h25, 4'h6, 8'h47, 0,  0, 3};
      vecs[4]  = '{4'b1111, 8'h15, 8'h26, 4'h7, 8'h48, 3,  2, 0};
      vecs[5]  = '{4'b0001, 8'h48, 8'h28, 4'h1, 8'h08, 4,  0, 0};
      vecs[6]  = '{4'b1000, 8'hA0, 8'h0B, 4'hC, 8'hD0, 0,  0, 3};
      vecs[7]  = '{4'b0110, 8'h7E, 8'h3C, 4'h9, 8'hF1, 2, 10, 1};
      vecs[8]  = '{4'b0011, 8'h01, 8'hFF, 4'h0, 8'h00, 1,  0, 0};
      vecs[9]  = '{4'b1100, 8'hC3, 8'h5A, 4'hF, 8'hFF, 0,  3, 2};
      vecs[10] = '{4'b0100, 8'h66, 8'h99, 4'hA, 8'h55, 5,  0, 2};

      reset = 1'b0; req_valid = 4'h0; req_num = 32'h0; req_den = 32'h0;
      div_done = 1'b0; div_quotient = 4'h0; div_remainder = 8'h0; rsp_ready = 1'b0;
      @(negedge clock);
      check("reset_outputs", {14'h0, req_ready, div_start, div_num, div_den, rsp_valid},
            32'h0);
      check("reset_rsp", {17'h0, rsp_id, rsp_quotient, rsp_remainder, rsp_error}, 32'h0);
      reset = 1'b1;
      ptr_m = 0;
      @(negedge clock);
      check("idle_no_req", 32'(req_ready), 32'h0);

      for (int i = 0; i < 11; i++) begin
         do_txn(vecs[i].mask, vecs[i].num, vecs[i].den, vecs[i].q, vecs[i].r,
                vecs[i].lat, vecs[i].stall, vecs[i].exp_id);
      end

      // stray done while idle must not produce a response or move the pointer
      div_done = 1'b1; div_quotient = 4'hE; div_remainder = 8'hEE;
      @(negedge clock);
      div_done = 1'b0;
      check("stray_rsp", 32'(rsp_valid), 32'h0);
      check("stray_start", 32'(div_start), 32'h0);
      @(negedge clock);
      check("stray_rsp2", 32'(rsp_valid), 32'h0);

      for (int i = 0; i < 40; i++) begin
         do_txn(4'($urandom_range(1, 15)), 8'($urandom), 8'($urandom), 4'($urandom),
                8'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), -1);
      end

      // asynchronous reset while waiting on the divider
      req_valid = 4'b0100; req_num[23:16] = 8'h5A; req_den[23:16] = 8'hA5;
      @(negedge clock);
      req_valid = 4'h0;
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("mid_reset_out", {14'h0, req_ready, div_start, div_num, div_den, rsp_valid}, 32'h0);
      check("mid_reset_rsp", {17'h0, rsp_id, rsp_quotient, rsp_remainder, rsp_error}, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      ptr_m = 0;
      div_done = 1'b1; div_quotient = 4'hF; div_remainder = 8'hFF;
      @(negedge clock);
      div_done = 1'b0;
      check("late_done_rsp", 32'(rsp_valid), 32'h0);
      @(negedge clock);
      check("late_done_rsp2", 32'(rsp_valid), 32'h0);
      check("late_done_start", 32'(div_start), 32'h0);
      req_valid = 4'b1111;
      #1;
      check("post_reset_grant", 32'(req_ready), 32'h1);
      do_txn(4'b1111, 8'h42, 8'h24, 4'h2, 8'h10, 1, 0, -1);

`ifdef FLOAT_DIV_TIMEOUT_EN
      timeout_txn(1'b0);
      timeout_txn(1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
